// File: rtl/alu_bist_pkg.sv
// Shared types, constants and the 32-bit reference model for the ALU self-test driver.
// The reference model and LFSR look-ahead are fixed at ALU_W bits; instantiate with WIDTH == ALU_W.
package alu_bist_pkg;

    localparam int ALU_W  = 32;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [ALU_W-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic [3:0]       flags;
    } alu_resp_t;

    // Galois step, shift right: feedback bit q[0] is folded back through the taps.
    function automatic logic [ALU_W-1:0] lfsr_step(input logic [ALU_W-1:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic alu_resp_t alu_ref(input logic [ALU_W-1:0] a,
                                          input logic [ALU_W-1:0] b,
                                          input alu_op_e          op);
        alu_resp_t      rsp;
        logic [ALU_W:0] sum;
        rsp = '0;
        sum = '0;
        case (op)
            ADD: begin
                sum               = {1'b0, a} + {1'b0, b};
                rsp.result        = sum[ALU_W-1:0];
                rsp.flags[FLAG_C] = sum[ALU_W];
                rsp.flags[FLAG_V] = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            SUB: begin
                sum               = {1'b0, a} + {1'b0, ~b} + (ALU_W+1)'(1);
                rsp.result        = sum[ALU_W-1:0];
                rsp.flags[FLAG_C] = sum[ALU_W];
                rsp.flags[FLAG_V] = (a[ALU_W-1] != b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            AND:     rsp.result = a & b;
            default: rsp.result = a | b;
        endcase
        rsp.flags[FLAG_N] = rsp.result[ALU_W-1];
        rsp.flags[FLAG_Z] = (rsp.result == '0);
        return rsp;
    endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Control/status and ALU operand/response bundle between the self-test driver and its environment.
interface alu_bist_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [15:0]      fail_index;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    modport master (
        input  start, alu_result, alu_flags,
        output busy, done, pass, err_count, fail_index, alu_a, alu_b, alu_ctrl
    );

    modport slave (
        output start, alu_result, alu_flags,
        input  busy, done, pass, err_count, fail_index, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/bist_lfsr.sv
// Right-shifting Galois LFSR with seed reload; holds its value unless stepped.
module bist_lfsr
    import alu_bist_pkg::*;
#(
    parameter int               WIDTH = ALU_W,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_tap
            assign w_q_next[gi] = r_q[gi+1] ^ (TAPS[gi] & r_q[0]);
        end
    endgenerate
    assign w_q_next[WIDTH-1] = TAPS[WIDTH-1] & r_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= SEED;
        end else if (load) begin
            r_q <= SEED;
        end else if (step) begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;
endmodule

// File: rtl/alu_bist.sv
// ALU self-test driver: applies corner and LFSR operand pairs with ADD/SUB/AND/OR,
// checks the combinational ALU response one cycle later and reports pass/fail status.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int               WIDTH       = ALU_W,
    parameter int               NUM_VECTORS = 256,
    parameter logic [WIDTH-1:0] SEED_A      = 32'hACE1_2F3B,
    parameter logic [WIDTH-1:0] SEED_B      = 32'h1357_9BDF
) (
    input  logic       clk,
    input  logic       reset,
    alu_bist_if.master bus
);
    localparam logic [15:0]      LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [WIDTH-1:0] CORNER_A0 = '1;
    localparam logic [WIDTH-1:0] CORNER_A1 = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] CORNER_B  = WIDTH'(1);

    state_e           r_state;
    state_e           w_state_next;
    logic [15:0]      r_idx;
    logic [15:0]      w_idx_next;
    logic [15:0]      r_err_count;
    logic [15:0]      r_fail_index;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [1:0]       r_alu_ctrl;
    logic [WIDTH-1:0] w_lfsr_a;
    logic [WIDTH-1:0] w_lfsr_b;
    logic [WIDTH-1:0] w_opnd_a;
    logic [WIDTH-1:0] w_opnd_b;
    logic             w_accept;
    logic             w_last;
    logic             w_step;
    logic             w_enter_drive;
    logic             w_mismatch;
    alu_resp_t        w_ref;

    bist_lfsr #(.WIDTH(WIDTH), .TAPS(WIDTH'(LFSR_TAPS)), .SEED(SEED_A)) u_lfsr_a (
        .clk(clk), .reset(reset), .load(w_accept), .step(w_step), .q(w_lfsr_a)
    );

    bist_lfsr #(.WIDTH(WIDTH), .TAPS(WIDTH'(LFSR_TAPS)), .SEED(SEED_B)) u_lfsr_b (
        .clk(clk), .reset(reset), .load(w_accept), .step(w_step), .q(w_lfsr_b)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = DRIVE;
                end
            end
            DRIVE: w_state_next = CHECK;
            CHECK: begin
                w_step = (r_idx[1:0] == 2'b11) && (r_idx >= 16'd8);
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRIVE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_drive = (w_state_next == DRIVE);
    assign w_idx_next    = w_accept ? 16'd0 : r_idx + 16'd1;

    // The LFSRs advance on the same edge that loads the next operands, so look one step ahead.
    always_comb begin
        w_opnd_a = w_step ? lfsr_step(w_lfsr_a) : w_lfsr_a;
        w_opnd_b = w_step ? lfsr_step(w_lfsr_b) : w_lfsr_b;
        if (w_idx_next < 16'd4) begin
            w_opnd_a = CORNER_A0;
            w_opnd_b = CORNER_B;
        end else if (w_idx_next < 16'd8) begin
            w_opnd_a = CORNER_A1;
            w_opnd_b = CORNER_B;
        end
    end

    assign w_ref      = alu_ref(r_alu_a, r_alu_b, alu_op_e'(r_alu_ctrl));
    assign w_mismatch = (bus.alu_result != w_ref.result) || (bus.alu_flags != w_ref.flags);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == DRIVE) || (w_state_next == CHECK);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= '0;
            r_err_count  <= '0;
            r_fail_index <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
        end else begin
            if (w_accept) begin
                r_err_count  <= '0;
                r_fail_index <= '0;
                r_done       <= 1'b0;
                r_pass       <= 1'b0;
            end else if (r_state == CHECK) begin
                if (w_mismatch) begin
                    if (r_err_count != 16'hFFFF) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                    if (r_err_count == 16'd0) begin
                        r_fail_index <= r_idx;
                    end
                end
                if (w_last) begin
                    r_done <= 1'b1;
                    r_pass <= !w_mismatch && (r_err_count == 16'd0);
                end
            end
            if (w_enter_drive) begin
                r_idx      <= w_idx_next;
                r_alu_a    <= w_opnd_a;
                r_alu_b    <= w_opnd_b;
                r_alu_ctrl <= w_idx_next[1:0];
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err_count;
    assign bus.fail_index = r_fail_index;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_ctrl   = r_alu_ctrl;
endmodule
